// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch stage with an IF/ID pipeline register.
//
// The PC register addresses instruction memory combinationally; each clock
// the fetched word and its address are captured into IF/ID. The next PC is
// picked with this priority:
//   1. a downstream redirect (taken branch / jr),
//   2. a j/jal sitting in IF/ID (resolved here, one stage early),
//   3. stall (hold everything),
//   4. sequential fetch (pc + 4).
// Redirects and decode jumps flush IF/ID, which costs exactly one bubble.
//
// Ports:
//   clk              single clock, rising edge
//   rst_n            asynchronous active-low reset
//   imem_addr        fetch address (equals the PC register)
//   imem_instr       instruction returned for imem_addr, same cycle
//   stall            hold PC and IF/ID
//   redirect_en      load PC from redirect_target and flush IF/ID
//   redirect_target  redirect destination (low two bits are forced to 0)
//   ifid_instr       registered instruction handed to decode
//   ifid_pc          registered address of ifid_instr
//   ifid_valid       1 = ifid_instr is live, 0 = bubble
//   align_err        sticky flag: a redirect target was not word aligned
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [31:0] redirect_target,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic        ifid_valid,
  output logic        align_err
);

  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;

  logic [31:0] pc;
  logic [31:0] ifid_pc_plus4;
  logic [31:0] jump_target;
  logic        decode_jump;

  assign imem_addr = pc;

  // A bubble in IF/ID (ifid_valid=0, instr all zeros) must never look like
  // a jump, so the opcode match is qualified by ifid_valid.
  assign ifid_pc_plus4 = ifid_pc + 32'd4;
  assign decode_jump   = ifid_valid &&
                         ((ifid_instr[31:26] == OP_J) || (ifid_instr[31:26] == OP_JAL));
  assign jump_target   = {ifid_pc_plus4[31:28], ifid_instr[25:0], 2'b00};

  // PC and IF/ID update. Redirect beats a decode jump, and both beat
  // stall; a flush clears the whole IF/ID register so the squashed
  // fetch leaves no trace.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      ifid_instr <= 32'd0;
      ifid_pc    <= 32'd0;
      ifid_valid <= 1'b0;
    end else if (redirect_en) begin
      pc         <= {redirect_target[31:2], 2'b00};
      ifid_instr <= 32'd0;
      ifid_pc    <= 32'd0;
      ifid_valid <= 1'b0;
    end else if (decode_jump) begin
      pc         <= jump_target;
      ifid_instr <= 32'd0;
      ifid_pc    <= 32'd0;
      ifid_valid <= 1'b0;
    end else if (!stall) begin
      pc         <= pc + 32'd4;
      ifid_instr <= imem_instr;
      ifid_pc    <= pc;
      ifid_valid <= 1'b1;
    end
  end

  // Sticky misalignment flag; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      align_err <= 1'b0;
    end else if (redirect_en && (redirect_target[1:0] != 2'b00)) begin
      align_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios followed by randomized
// traffic, all checked against a behavioural model of the fetch stage.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        stall;
  logic        redirect_en;
  logic [31:0] redirect_target;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic        ifid_valid;
  logic        align_err;

  logic        memMode;
  int          checks = 0;
  int          errors = 0;

  // Behavioural model state
  logic [31:0] mPc;
  logic [31:0] mInstr;
  logic [31:0] mIfPc;
  logic        mValid;
  logic        mAlign;

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .imem_addr(imem_addr),
    .imem_instr(imem_instr),
    .stall(stall),
    .redirect_en(redirect_en),
    .redirect_target(redirect_target),
    .ifid_instr(ifid_instr),
    .ifid_pc(ifid_pc),
    .ifid_valid(ifid_valid),
    .align_err(align_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents. Mode 0: addi words, with a jal at 36 and
  // a j at 40. Mode 1: hashed contents with occasional j/jal and zero words.
  function automatic logic [31:0] memWord(input logic [31:0] addr, input logic mode);
    logic [31:0] h;
    if (!mode) begin
      if (addr == 32'd36) return 32'h0C00_000D;
      if (addr == 32'd40) return 32'h0800_000D;
      return {16'h2008, addr[15:0]};
    end
    h = addr * 32'h9E37_79B1 + 32'h7F4A_7C15;
    h = h ^ (h >> 15);
    if (h[2:0] == 3'd0) return {5'b00001, h[27], h[25:0]};
    if (h[4:0] == 5'd9) return 32'd0;
    return {6'b001000, h[25:0]};
  endfunction

  assign imem_instr = memWord(imem_addr, memMode);

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    mPc = RESET_PC; mInstr = 0; mIfPc = 0; mValid = 0; mAlign = 0;
  endtask

  // One cycle of the fetch stage as described by its rules.
  task automatic modelStep(input logic s, input logic r, input logic [31:0] t);
    logic [31:0] fetched;
    logic        isJump;
    fetched = memWord(mPc, memMode);
    isJump  = mValid && ((mInstr[31:26] == 6'd2) || (mInstr[31:26] == 6'd3));
    if (r) begin
      mPc = t & ~32'd3;
      if ((t % 4) != 0) mAlign = 1;
      mInstr = 0; mIfPc = 0; mValid = 0;
    end else if (isJump) begin
      mPc = ((mIfPc + 32'd4) & 32'hF000_0000) | ((mInstr & 32'h03FF_FFFF) << 2);
      mInstr = 0; mIfPc = 0; mValid = 0;
    end else if (!s) begin
      mInstr = fetched; mIfPc = mPc; mValid = 1;
      mPc = mPc + 32'd4;
    end
  endtask

  task automatic compareAll(input string tag);
    checkOutput({tag, ".imem_addr"},  imem_addr,  mPc);
    checkOutput({tag, ".ifid_instr"}, ifid_instr, mInstr);
    checkOutput({tag, ".ifid_pc"},    ifid_pc,    mIfPc);
    checkOutput({tag, ".ifid_valid"}, {31'd0, ifid_valid}, {31'd0, mValid});
    checkOutput({tag, ".align_err"},  {31'd0, align_err},  {31'd0, mAlign});
  endtask

  // Drive one cycle of inputs (called just after a rising edge), advance the
  // model, then sample 1 time unit after the next rising edge.
  task automatic applyStimulus(input logic s, input logic r, input logic [31:0] t, input string tag);
    stall = s; redirect_en = r; redirect_target = t;
    modelStep(s, r, t);
    @(posedge clk);
    #1;
    compareAll(tag);
  endtask

  initial begin
    memMode = 1'b0;
    stall = 0; redirect_en = 0; redirect_target = 0;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("rst.imem_addr", imem_addr, RESET_PC);
    checkOutput("rst.ifid_valid", {31'd0, ifid_valid}, 32'd0);
    checkOutput("rst.ifid_instr", ifid_instr, 32'd0);
    checkOutput("rst.align_err", {31'd0, align_err}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Straight-line fetch from reset
    checkOutput("seq.addr0", imem_addr, 32'd0);
    applyStimulus(0, 0, 0, "seq1");
    checkOutput("seq1.addr", imem_addr, 32'd4);
    checkOutput("seq1.ifid_pc", ifid_pc, 32'd0);
    checkOutput("seq1.valid", {31'd0, ifid_valid}, 32'd1);
    applyStimulus(0, 0, 0, "seq2");
    checkOutput("seq2.addr", imem_addr, 32'd8);
    checkOutput("seq2.ifid_pc", ifid_pc, 32'd4);
    applyStimulus(0, 0, 0, "seq3");
    checkOutput("seq3.addr", imem_addr, 32'd12);
    checkOutput("seq3.ifid_pc", ifid_pc, 32'd8);
    for (int i = 4; i <= 10; i++) applyStimulus(0, 0, 0, "seq");
    checkOutput("jal.ifid_instr", ifid_instr, 32'h0C00_000D);
    checkOutput("jal.ifid_pc", ifid_pc, 32'd36);

    // Decode jump: jal 13 from 36 -> 52, one bubble
    applyStimulus(0, 0, 0, "jal1");
    checkOutput("jal1.addr", imem_addr, 32'h34);
    checkOutput("jal1.valid", {31'd0, ifid_valid}, 32'd0);
    applyStimulus(0, 0, 0, "jal2");
    checkOutput("jal2.ifid_pc", ifid_pc, 32'd52);
    checkOutput("jal2.valid", {31'd0, ifid_valid}, 32'd1);

    // Redirect overrides stall
    applyStimulus(1, 1, 32'h28, "redStall");
    checkOutput("redStall.addr", imem_addr, 32'h28);
    checkOutput("redStall.valid", {31'd0, ifid_valid}, 32'd0);
    checkOutput("redStall.align", {31'd0, align_err}, 32'd0);

    // Redirect beats a j sitting in IF/ID
    applyStimulus(0, 0, 0, "jLoad");
    checkOutput("jLoad.ifid_instr", ifid_instr, 32'h0800_000D);
    applyStimulus(0, 1, 32'h50, "redJump");
    checkOutput("redJump.addr", imem_addr, 32'h50);

    // Misaligned redirect sets the sticky flag
    applyStimulus(0, 1, 32'h31, "misal");
    checkOutput("misal.addr", imem_addr, 32'h30);
    checkOutput("misal.align", {31'd0, align_err}, 32'd1);
    for (int i = 0; i < 10; i++) applyStimulus(1'($urandom_range(1)), 0, 0, "misalHold");
    checkOutput("misal10.align", {31'd0, align_err}, 32'd1);

    // PC wraparound, then async reset in the middle of a stall
    applyStimulus(0, 1, 32'hFFFF_FFFC, "wrapRed");
    applyStimulus(0, 0, 0, "wrap1");
    checkOutput("wrap1.addr", imem_addr, 32'h0);
    applyStimulus(0, 0, 0, "wrap2");
    applyStimulus(1, 0, 0, "stallHold");
    checkOutput("stallHold.addr", imem_addr, 32'h4);
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("asyncRst.addr", imem_addr, RESET_PC);
    checkOutput("asyncRst.valid", {31'd0, ifid_valid}, 32'd0);
    checkOutput("asyncRst.ifid_pc", ifid_pc, 32'd0);
    checkOutput("asyncRst.align", {31'd0, align_err}, 32'd0);
    @(posedge clk);
    #1;
    compareAll("rstHeld");
    rst_n = 1'b1;

    // Randomized traffic over hashed memory contents
    memMode = 1'b1;
    for (int i = 0; i < 600; i++) begin
      logic        s;
      logic        r;
      logic [31:0] t;
      s = ($urandom_range(3) == 0);
      r = ($urandom_range(9) == 0);
      t = $urandom;
      if ($urandom_range(3) != 0) t[1:0] = 2'b00;
      if ($urandom_range(199) == 0) begin
        rst_n = 1'b0;
        #1;
        modelReset();
        compareAll("rndRst");
        rst_n = 1'b1;
      end
      applyStimulus(s, r, t, "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port imem_addr, output, 32 bits: fetch address to the instruction memory, driven combinationally from the PC register.
REQ-005 SHALL have port imem_instr, input, 32 bits: instruction returned combinationally by the instruction memory for imem_addr.
REQ-006 SHALL have port stall, input, 1 bit: hold the PC and the IF/ID register.
REQ-007 SHALL have port redirect_en, input, 1 bit: taken branch or jr redirect from downstream.
REQ-008 SHALL have port redirect_target, input, 32 bits: new PC when redirect_en=1.
REQ-009 SHALL have port ifid_instr, output, 32 bits: registered instruction to decode.
REQ-010 SHALL have port ifid_pc, output, 32 bits: registered address of ifid_instr.
REQ-011 SHALL have port ifid_valid, output, 1 bit: 1 means ifid_instr is live, 0 means bubble.
REQ-012 SHALL have port align_err, output, 1 bit: sticky flag set on a misaligned redirect target.

Function
REQ-013 SHALL drive imem_addr = pc every cycle, with no additional latency.
REQ-014 SHALL compute next-PC with this priority: redirect_en, then decode jump, then stall, then sequential.
REQ-015 On redirect_en=1 (regardless of stall), SHALL load pc <= {redirect_target[31:2],2'b00} and flush IF/ID (ifid_valid<=0, ifid_instr<=0, ifid_pc<=0).
REQ-016 SHALL set align_err<=1 when redirect_en=1 and redirect_target[1:0]!=0; align_err stays set until reset.
REQ-017 SHALL treat as a decode jump the case ifid_valid=1 and ifid_instr[31:26] is 6'b000010 (j) or 6'b000011 (jal), with redirect_en=0.
REQ-018 On a decode jump (regardless of stall), SHALL load pc <= {ifid_pc_plus4[31:28], ifid_instr[25:0], 2'b00}, where ifid_pc_plus4 = ifid_pc+4, and flush IF/ID, squashing the instruction currently being fetched.
REQ-019 When stall=1 with no redirect and no decode jump, SHALL hold pc, ifid_instr, ifid_pc and ifid_valid unchanged.
REQ-020 In the sequential case, SHALL load ifid_instr<=imem_instr, ifid_pc<=pc, ifid_valid<=1 and pc<=pc+4.
REQ-021 SHALL perform all PC arithmetic modulo 2^32, so pc 32'hFFFF_FFFC advances to 32'h0000_0000 without a flag.
REQ-022 If redirect_en and a decode jump occur in the same cycle, SHALL let the redirect win and discard the jump.
REQ-023 SHALL impose a one-cycle redirect penalty: exactly one bubble (ifid_valid=0) follows each redirect or decode jump before the target instruction appears in IF/ID.
REQ-024 SHALL not treat an all-zero ifid_instr while ifid_valid=0 as a jump or as any other action.

Reset
REQ-025 While rst_n=0, SHALL immediately (asynchronously) force pc=RESET_PC, ifid_instr=0, ifid_pc=0, ifid_valid=0, align_err=0.
REQ-026 On the first rising clk edge after rst_n rises, SHALL fetch from RESET_PC; ifid_valid SHALL be 1 after that edge if stall=0.
REQ-027 Reset asserted mid-operation, including mid-stall or mid-redirect, SHALL abort the operation with no partial update surviving.

Verification
REQ-028 Reset release, stall=0, memory returning addi words -> imem_addr 0,4,8,12 on successive cycles; ifid_pc lags by one cycle with ifid_valid=1.
REQ-029 IF/ID holding 32'h0C00000D at ifid_pc=36 -> next pc=52 (0x34); IF/ID shows bubble for one cycle, then ifid_pc=52.
REQ-030 stall=1 and redirect_en=1 with target 0x28 in the same cycle -> pc=0x28, ifid_valid=0, align_err=0.
REQ-031 redirect_target=0x31 -> pc=0x30, align_err=1, and align_err still 1 after 10 further cycles.
REQ-032 Redirect and decode jump (IF/ID = j to 0x34) in the same cycle with redirect_target=0x50 -> pc=0x50.
REQ-033 pc=0xFFFFFFFC, stall=0 -> pc=0x0 next cycle; asserting rst_n=0 mid-stall -> pc=RESET_PC immediately, without waiting for a clk edge.
